// File: rtl/jt12_amlfo.sv
`default_nettype none
// ============================================================================
// jt12_amlfo : YM2612-style LFO producing AM depth and PM index per sample
// Rev 1.0
// ============================================================================
module jt12_amlfo #(
    parameter int DIV_W = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       zero,
    input  logic       lfo_en,
    input  logic [2:0] lfo_freq,
    output logic [6:0] am,
    output logic [4:0] pm,
    output logic       lfo_step
);

    logic [DIV_W-1:0] div_q, div_d, lim_m1;
    logic [6:0]       cnt_q, cnt_d;
    logic [6:0]       am_q, am_d;
    logic [4:0]       pm_q, pm_d;
    logic             step_q, step_d;

    // Terminal divider value (limit - 1) for each rate setting
    always_comb begin
        lim_m1 = DIV_W'(107);
        case (lfo_freq)
            3'd0: lim_m1 = DIV_W'(107);
            3'd1: lim_m1 = DIV_W'(76);
            3'd2: lim_m1 = DIV_W'(70);
            3'd3: lim_m1 = DIV_W'(66);
            3'd4: lim_m1 = DIV_W'(61);
            3'd5: lim_m1 = DIV_W'(43);
            3'd6: lim_m1 = DIV_W'(7);
            3'd7: lim_m1 = DIV_W'(4);
        endcase
    end

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        step_d = 1'b0;
        if (!lfo_en) begin
            div_d = '0;
            cnt_d = '0;
        end else if (zero) begin
            // >= so a rate change that lowers the limit wraps immediately
            if (div_q >= lim_m1) begin
                div_d  = '0;
                cnt_d  = cnt_q + 7'd1;
                step_d = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Outputs derive from next-state cnt so they move on the same edge as cnt
    always_comb begin
        am_d = '0;
        pm_d = '0;
        if (lfo_en) begin
            am_d = cnt_d[6] ? {cnt_d[5:0], 1'b0} : {~cnt_d[5:0], 1'b0};
            pm_d = cnt_d[6:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            cnt_q  <= '0;
            am_q   <= '0;
            pm_q   <= '0;
            step_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            am_q   <= am_d;
            pm_q   <= pm_d;
            step_q <= step_d;
        end
    end

    assign am       = am_q;
    assign pm       = pm_q;
    assign lfo_step = step_q;

endmodule
`default_nettype wire

// File: tb/tb_jt12_amlfo.sv
`default_nettype none
// ============================================================================
// tb_jt12_amlfo : directed self-checking bench for jt12_amlfo
// Rev 1.0
// ============================================================================
module tb_jt12_amlfo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       zero = 1'b0;
    logic       lfo_en = 1'b0;
    logic [2:0] lfo_freq = 3'd0;
    logic [6:0] am;
    logic [4:0] pm;
    logic       lfo_step;

    int n_cmp = 0;
    int n_fail = 0;

    jt12_amlfo #(.DIV_W(7)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .zero     (zero),
        .lfo_en   (lfo_en),
        .lfo_freq (lfo_freq),
        .am       (am),
        .pm       (pm),
        .lfo_step (lfo_step)
    );

    always #5 clk = ~clk;

    // One-cycle zero pulse; returns at the negedge after the counting edge
    task automatic pulse();
        @(negedge clk) zero = 1'b1;
        @(negedge clk) zero = 1'b0;
    endtask

    task automatic restart(input logic [2:0] f);
        @(negedge clk);
        zero = 1'b0; lfo_en = 1'b0; lfo_freq = f;
        @(negedge clk) lfo_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (am !== 7'd0) begin n_fail++; $display("FAIL reset_am got %0d want 0", am); end
        n_cmp++; if (pm !== 5'd0) begin n_fail++; $display("FAIL reset_pm got %0d want 0", pm); end
        n_cmp++; if (lfo_step !== 1'b0) begin n_fail++; $display("FAIL reset_step got %0b want 0", lfo_step); end
        lfo_en = 1'b1; lfo_freq = 3'd7;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (am !== 7'd126) begin n_fail++; $display("FAIL enable_am got %0d want 126", am); end
    endtask

    task automatic test_first_step();
        int early;
        early = 0;
        for (int i = 1; i <= 4; i++) begin
            pulse();
            if (lfo_step) early++;
        end
        n_cmp++; if (early !== 0) begin n_fail++; $display("FAIL first_early got %0d steps want 0", early); end
        pulse();
        n_cmp++; if (lfo_step !== 1'b1) begin n_fail++; $display("FAIL first_step got %0b want 1", lfo_step); end
        n_cmp++; if (am !== 7'd124) begin n_fail++; $display("FAIL first_am got %0d want 124", am); end
        n_cmp++; if (pm !== 5'd0) begin n_fail++; $display("FAIL first_pm got %0d want 0", pm); end
        @(negedge clk);
        n_cmp++; if (lfo_step !== 1'b0) begin n_fail++; $display("FAIL step_width got %0b want 0", lfo_step); end
    endtask

    task automatic test_wrap();
        int m;
        int exp_am;
        int bad;
        m = 0; bad = 0;
        restart(3'd6);
        for (int i = 1; i <= 1024; i++) begin
            pulse();
            if (i % 8 == 0) begin
                m = (m + 1) % 128;
                exp_am = (m < 64) ? (126 - 2 * m) : (2 * (m - 64));
                n_cmp++;
                if (lfo_step !== 1'b1 || am !== exp_am[6:0] || pm !== 5'(m / 4)) begin
                    n_fail++;
                    if (bad < 5) $display("FAIL wrap_step%0d got step=%0b am=%0d pm=%0d want step=1 am=%0d pm=%0d",
                                          m, lfo_step, am, pm, exp_am, m / 4);
                    bad++;
                end
            end else if (lfo_step !== 1'b0) begin
                n_cmp++; n_fail++;
                if (bad < 5) $display("FAIL wrap_idle pulse %0d got step=1 want 0", i);
                bad++;
            end
        end
        n_cmp++; if (am !== 7'd126 || pm !== 5'd0) begin n_fail++; $display("FAIL wrap_end got am=%0d pm=%0d want 126/0", am, pm); end
    endtask

    task automatic test_freq_change();
        int steps;
        steps = 0;
        restart(3'd0);
        for (int i = 0; i < 100; i++) begin
            pulse();
            if (lfo_step) steps++;
        end
        n_cmp++; if (steps !== 0) begin n_fail++; $display("FAIL fchg_pre got %0d steps want 0", steps); end
        lfo_freq = 3'd5;
        pulse();
        n_cmp++; if (lfo_step !== 1'b1 || am !== 7'd124) begin n_fail++; $display("FAIL fchg_wrap got step=%0b am=%0d want 1/124", lfo_step, am); end
        steps = 0;
        for (int i = 0; i < 43; i++) begin
            pulse();
            if (lfo_step) steps++;
        end
        n_cmp++; if (steps !== 0) begin n_fail++; $display("FAIL fchg_div0 got %0d steps want 0", steps); end
        pulse();
        n_cmp++; if (lfo_step !== 1'b1 || am !== 7'd122) begin n_fail++; $display("FAIL fchg_next got step=%0b am=%0d want 1/122", lfo_step, am); end
    endtask

    task automatic test_disable();
        int early;
        early = 0;
        restart(3'd7);
        repeat (350) pulse();
        n_cmp++; if (am !== 7'd12 || pm !== 5'd17) begin n_fail++; $display("FAIL cnt70 got am=%0d pm=%0d want 12/17", am, pm); end
        lfo_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (am !== 7'd0 || pm !== 5'd0 || lfo_step !== 1'b0) begin n_fail++; $display("FAIL dis got am=%0d pm=%0d step=%0b want 0/0/0", am, pm, lfo_step); end
        zero = 1'b1;
        @(negedge clk) zero = 1'b0;
        n_cmp++; if (am !== 7'd0 || lfo_step !== 1'b0) begin n_fail++; $display("FAIL dis_zero got am=%0d step=%0b want 0/0", am, lfo_step); end
        lfo_en = 1'b1;
        @(negedge clk);
        n_cmp++; if (am !== 7'd126 || pm !== 5'd0) begin n_fail++; $display("FAIL reen got am=%0d pm=%0d want 126/0", am, pm); end
        for (int i = 0; i < 4; i++) begin
            pulse();
            if (lfo_step) early++;
        end
        n_cmp++; if (early !== 0) begin n_fail++; $display("FAIL reen_early got %0d steps want 0", early); end
        pulse();
        n_cmp++; if (lfo_step !== 1'b1 || am !== 7'd124) begin n_fail++; $display("FAIL reen_step got step=%0b am=%0d want 1/124", lfo_step, am); end
    endtask

    task automatic test_async_reset();
        int early;
        early = 0;
        restart(3'd7);
        repeat (10) pulse();
        n_cmp++; if (lfo_step !== 1'b1 || am !== 7'd122) begin n_fail++; $display("FAIL prerst got step=%0b am=%0d want 1/122", lfo_step, am); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (am !== 7'd0 || pm !== 5'd0 || lfo_step !== 1'b0) begin n_fail++; $display("FAIL async_rst got am=%0d pm=%0d step=%0b want 0/0/0", am, pm, lfo_step); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (am !== 7'd126) begin n_fail++; $display("FAIL postrst_am got %0d want 126", am); end
        for (int i = 0; i < 4; i++) begin
            pulse();
            if (lfo_step) early++;
        end
        n_cmp++; if (early !== 0) begin n_fail++; $display("FAIL postrst_early got %0d steps want 0", early); end
        pulse();
        n_cmp++; if (lfo_step !== 1'b1 || am !== 7'd124) begin n_fail++; $display("FAIL postrst_step got step=%0b am=%0d want 1/124", lfo_step, am); end
    endtask

    task automatic test_zero_held();
        restart(3'd7);
        zero = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (lfo_step !== (k == 5)) begin n_fail++; $display("FAIL held_cycle%0d got step=%0b want %0b", k, lfo_step, (k == 5)); end
        end
        zero = 1'b0;
        @(negedge clk);
        n_cmp++; if (lfo_step !== 1'b0 || am !== 7'd124) begin n_fail++; $display("FAIL held_after got step=%0b am=%0d want 0/124", lfo_step, am); end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_wrap();
        test_freq_change();
        test_disable();
        test_async_reset();
        test_zero_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt12_amlfo.md
JT12_AMLFO -- requirements
Module: jt12_amlfo

Interface
REQ-001 Parameter DIV_W, default 7: width of the sample divider counter.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock for all state; rising edge active.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-004 The module SHALL have port zero, input, 1 bit: one-cycle pulse per output sample (once every 24 operator slots).
REQ-005 The module SHALL have port lfo_en, input, 1 bit: LFO enable from register 0x22 bit 3.
REQ-006 The module SHALL have port lfo_freq, input, 3 bits: LFO rate select from register 0x22 bits 2:0.
REQ-007 The module SHALL have port am, output, 7 bits: amplitude-modulation depth, consumed by the envelope generator.
REQ-008 The module SHALL have port pm, output, 5 bits: phase-modulation index, consumed by the phase generator.
REQ-009 The module SHALL have port lfo_step, output, 1 bit: one-cycle pulse marking each LFO count advance.

Function
REQ-010 The module SHALL hold a divider counter div (DIV_W bits) and an LFO counter cnt (7 bits, wraps 127 -> 0).
REQ-011 Divider limit by lfo_freq (samples per LFO step) SHALL be: 0:108, 1:77, 2:71, 3:67, 4:62, 5:44, 6:8, 7:5.
REQ-012 div SHALL change only on a clk edge where zero=1 and lfo_en=1; on all other cycles it holds.
REQ-013 On such an edge, if div >= limit-1, div SHALL go to 0, cnt SHALL go to cnt+1 mod 128, and lfo_step SHALL be 1 for that following cycle only.
REQ-014 On such an edge, if div < limit-1, div SHALL go to div+1 and cnt SHALL hold.
REQ-015 The >= comparison SHALL apply when lfo_freq changes mid-count: a limit lowered below the current div wraps on the next zero pulse, with no stall and no 128-sample overflow.
REQ-016 lfo_freq SHALL be sampled live every cycle; no latching is required.
REQ-017 When lfo_en=0, div and cnt SHALL be forced to 0 on every clk edge, and lfo_step SHALL be 0.
REQ-018 On a 0 -> 1 transition of lfo_en, counting SHALL restart from div=0, cnt=0; the first step occurs after exactly limit zero pulses.
REQ-019 am SHALL be registered and computed from the next-state cnt, so am reflects the new cnt on the same edge that updates cnt.
REQ-020 am mapping SHALL be: if cnt[6]=0, am = {~cnt[5:0], 0}; else am = {cnt[5:0], 0}. This is an inverted triangle, even values 126 down to 0 and back up to 126.
REQ-021 pm SHALL be registered, computed from the next-state cnt as pm = cnt[6:2], with the same timing as am.
REQ-022 When lfo_en=0, am SHALL be 0 and pm SHALL be 0. This overrides REQ-020, under which cnt=0 would map to 126.
REQ-023 zero held high for several consecutive cycles SHALL count once per cycle; no edge detection is performed.
REQ-024 No output SHALL depend combinationally on any input; all outputs are flops.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately, without waiting for clk, set div=0, cnt=0, am=0, pm=0 and lfo_step=0.
REQ-026 Reset deassertion SHALL be the only reset path; rst_n may assert mid-count, and all state SHALL return to the values in REQ-025.
REQ-027 After deassertion, behaviour SHALL be identical to an lfo_en 0 -> 1 restart (REQ-018) if lfo_en=1.

Verification
REQ-028 Reset, then lfo_en=1, lfo_freq=7, with zero pulsed every 24 cycles -> first lfo_step after the 5th pulse, cnt=1, am=124, pm=0.
REQ-029 lfo_freq=6, run 128*8 zero pulses -> cnt wraps 127 -> 0; am sequence 126..0..126 (step 2); pm rises 0..31.
REQ-030 lfo_freq=0, div=100, then switch lfo_freq to 5 -> lfo_step on the next zero pulse, div=0.
REQ-031 Running at cnt=70, set lfo_en=0 -> next edge am=0, pm=0, cnt=0; re-enable -> first step after limit pulses.
REQ-032 Assert rst_n mid-count between clk edges -> all outputs 0 before the next clk edge.
REQ-033 zero held high for 5 consecutive cycles with lfo_freq=7 -> exactly one lfo_step, on the 5th cycle.
